// File: rtl/sct_pkg.sv
// Shared types and constants for the sct_step_counter slice.
package sct_pkg;

  typedef enum logic [1:0] {
    SCT_IDLE = 2'd0,
    SCT_RUN  = 2'd1,
    SCT_DONE = 2'd2
  } sct_state_e;

  localparam logic SCT_UP = 1'b1;
  localparam logic SCT_DN = 1'b0;

endpackage

// File: rtl/sct_next_cnt.sv
// Combinational next-count, wrap and terminal decode for the step counter.
// Saturation on terminal is present only when SCT_SAT_EN is defined.
module sct_next_cnt
  import sct_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt_cnt,
  output logic             wrap,
  output logic             tc
);

  assign tc = (up == SCT_UP) ? (cnt == MAX_VAL) : (cnt == '0);

  always_comb begin
    nxt_cnt = cnt;
    wrap    = 1'b0;
    if (up == SCT_UP) begin
      // Loaded values above MAX_VAL run to all-ones and wrap without tc.
      if (tc || (cnt == '1)) begin
        nxt_cnt = '0;
        wrap    = 1'b1;
      end else begin
        nxt_cnt = cnt + 1'b1;
      end
    end else begin
      if (tc) begin
        nxt_cnt = MAX_VAL;
        wrap    = 1'b1;
      end else begin
        nxt_cnt = cnt - 1'b1;
      end
    end
`ifdef SCT_SAT_EN
    if (sat && tc) begin
      nxt_cnt = cnt;
      wrap    = 1'b0;
    end
`endif
  end

`ifndef SCT_SAT_EN
  logic unused_sat;
  assign unused_sat = sat;
`endif

endmodule

// File: rtl/sct_step_counter.sv
// Registered step counter with clear/load/step priority and IDLE/RUN/DONE sequencer.
// Optional saturate-at-terminal mode is enabled by defining SCT_SAT_EN.
module sct_step_counter
  import sct_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             up,
  input  logic             sat,
  input  logic             step,
  input  logic             arm,
  input  logic             ack,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             co,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             co_q, co_d;
  sct_state_e       state_q, state_d;

  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_wrap;
  logic             tc_w;
  logic             ld_acc;
  logic             step_acc;

  sct_next_cnt #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .cnt     (cnt_q),
    .up      (up),
    .sat     (sat),
    .nxt_cnt (nxt_cnt),
    .wrap    (nxt_wrap),
    .tc      (tc_w)
  );

  // Only the highest-priority request acts: clr, then load, then step.
  assign ld_acc   = en & ld & ~clr;
  assign step_acc = en & step & ~clr & ~ld;

  always_comb begin
    cnt_d = cnt_q;
    co_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (ld_acc) begin
      cnt_d = ld_val;
    end else if (step_acc) begin
      cnt_d = nxt_cnt;
      co_d  = nxt_wrap;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCT_IDLE: if (en && arm) state_d = SCT_RUN;
      SCT_RUN: begin
        if (clr || ld_acc)        state_d = SCT_IDLE;
        else if (step_acc && tc_w) state_d = SCT_DONE;
      end
      SCT_DONE: if (ack) state_d = SCT_IDLE;
      default:  state_d = SCT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      co_q    <= 1'b0;
      state_q <= SCT_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      co_q    <= co_d;
      state_q <= state_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc   = tc_w;
  assign co   = co_q;
  assign busy = (state_q == SCT_RUN);
  assign done = (state_q == SCT_DONE);

endmodule

// File: tb/tb_sct_step_counter.sv
// Directed, table-driven bench for sct_step_counter at WIDTH=4 (MAX_VAL=15).
// Saturation expectations follow SCT_SAT_EN when it is defined for the build.
module tb_sct_step_counter;

  localparam int W = 4;

  // Control word bit order: {clr, ld, up, en, step, arm, ack, sat}
  localparam logic [7:0] C_CLR  = 8'h80;
  localparam logic [7:0] C_LD   = 8'h40;
  localparam logic [7:0] C_UP   = 8'h20;
  localparam logic [7:0] C_EN   = 8'h10;
  localparam logic [7:0] C_STEP = 8'h08;
  localparam logic [7:0] C_ARM  = 8'h04;
  localparam logic [7:0] C_ACK  = 8'h02;
  localparam logic [7:0] C_SAT  = 8'h01;
  localparam logic [7:0] U      = C_EN | C_UP;

  // Expected flag bit order: {tc, co, busy, done}
  localparam logic [3:0] F_TC   = 4'b1000;
  localparam logic [3:0] F_CO   = 4'b0100;
  localparam logic [3:0] F_BUSY = 4'b0010;
  localparam logic [3:0] F_DONE = 4'b0001;

  logic         clk = 1'b0;
  logic         rst, en, clr, ld, up, sat, step, arm, ack;
  logic [W-1:0] ld_val;
  logic [W-1:0] cnt;
  logic         tc, co, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ctl;
    logic [3:0] ldv;
    logic [3:0] ecnt;
    logic [3:0] eflg;
  } vec_t;

  vec_t vecs[$];

  sct_step_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .ld     (ld),
    .ld_val (ld_val),
    .up     (up),
    .sat    (sat),
    .step   (step),
    .arm    (arm),
    .ack    (ack),
    .cnt    (cnt),
    .tc     (tc),
    .co     (co),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] c, input logic [3:0] v,
                              input logic [3:0] ec, input logic [3:0] ef);
    vec_t r;
    r.ctl  = c;
    r.ldv  = v;
    r.ecnt = ec;
    r.eflg = ef;
    return r;
  endfunction

  task automatic drive(input logic [7:0] c, input logic [3:0] v);
    {clr, ld, up, en, step, arm, ack, sat} = c;
    ld_val = v;
  endtask

  task automatic check(input string nm, input logic [3:0] ec, input logic [3:0] ef);
    logic [7:0] act;
    logic [7:0] exp;
    act = {cnt, tc, co, busy, done};
    exp = {ec, ef};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d tc/co/busy/done=%b, want cnt=%0d tc/co/busy/done=%b",
               nm, act[7:4], act[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic cyc(input string nm, input logic [7:0] c, input logic [3:0] v,
                     input logic [3:0] ec, input logic [3:0] ef);
    drive(c, v);
    @(posedge clk);
    #1;
    check(nm, ec, ef);
  endtask

  initial begin
    // Up-count through the full range and wrap.
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk(U | C_STEP, 4'd0, 4'(k % 16), {(k % 16) == 15, k == 16, 2'b00}));
    // Load 3, count down through 0 to 15.
    vecs.push_back(mk(C_EN | C_LD,   4'd3, 4'd3,  4'b0000));
    vecs.push_back(mk(C_EN | C_STEP, 4'd0, 4'd2,  4'b0000));
    vecs.push_back(mk(C_EN | C_STEP, 4'd0, 4'd1,  4'b0000));
    vecs.push_back(mk(C_EN | C_STEP, 4'd0, 4'd0,  F_TC));
    vecs.push_back(mk(C_EN | C_STEP, 4'd0, 4'd15, F_CO));
    // Armed run from 13 to DONE, held until ack; arm with ack is ignored.
    vecs.push_back(mk(U | C_LD,   4'd13, 4'd13, 4'b0000));
    vecs.push_back(mk(U | C_ARM,  4'd0,  4'd13, F_BUSY));
    vecs.push_back(mk(U | C_STEP, 4'd0,  4'd14, F_BUSY));
    vecs.push_back(mk(U | C_STEP, 4'd0,  4'd15, F_TC | F_BUSY));
    vecs.push_back(mk(U | C_STEP, 4'd0,  4'd0,  F_CO | F_DONE));
    vecs.push_back(mk(U,          4'd0,  4'd0,  F_DONE));
    vecs.push_back(mk(U,          4'd0,  4'd0,  F_DONE));
    vecs.push_back(mk(U,          4'd0,  4'd0,  F_DONE));
    vecs.push_back(mk(U | C_ACK | C_ARM, 4'd0, 4'd0, 4'b0000));
    vecs.push_back(mk(U,          4'd0,  4'd0,  4'b0000));
    // clr beats ld and step, and aborts RUN; ld also aborts RUN.
    vecs.push_back(mk(U | C_ARM,  4'd0,  4'd0,  F_BUSY));
    vecs.push_back(mk(U | C_CLR | C_LD | C_STEP, 4'd9, 4'd0, 4'b0000));
    vecs.push_back(mk(U | C_ARM,  4'd0,  4'd0,  F_BUSY));
    vecs.push_back(mk(U | C_LD,   4'd7,  4'd7,  4'b0000));
    // en low freezes cnt and FSM in RUN.
    vecs.push_back(mk(U | C_ARM,  4'd0,  4'd7,  F_BUSY));
    vecs.push_back(mk(C_UP | C_STEP | C_LD | C_ARM | C_ACK, 4'd2, 4'd7, F_BUSY));

    rst = 1'b1;
    drive(8'h00, 4'd0);
    @(posedge clk);
    #1;
    check("reset_dn", 4'd0, F_TC);
    up = 1'b1;
    #1;
    check("reset_up", 4'd0, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      cyc($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].ldv, vecs[i].ecnt, vecs[i].eflg);

    // Reset mid-run at cnt=7.
    rst = 1'b1;
    cyc("rst_in_run", C_UP, 4'd0, 4'd0, 4'b0000);
    rst = 1'b0;

    // en low in IDLE: arm and step ignored.
    cyc("en0_idle", C_UP | C_ARM | C_STEP, 4'd0, 4'd0, 4'b0000);
    // clr acts even with en low.
    cyc("ld5", U | C_LD, 4'd5, 4'd5, 4'b0000);
    cyc("clr_en0", C_UP | C_CLR, 4'd0, 4'd0, 4'b0000);

    // Step at terminal with sat=1.
    cyc("ld15", U | C_LD, 4'd15, 4'd15, F_TC);
    cyc("arm15", U | C_ARM, 4'd0, 4'd15, F_TC | F_BUSY);
`ifdef SCT_SAT_EN
    cyc("sat_step", U | C_STEP | C_SAT, 4'd0, 4'd15, F_TC | F_DONE);
    cyc("sat_ack", U | C_ACK | C_SAT, 4'd0, 4'd15, F_TC);
    cyc("sat_hold", U | C_STEP | C_SAT, 4'd0, 4'd15, F_TC);
`else
    cyc("sat_step", U | C_STEP | C_SAT, 4'd0, 4'd0, F_CO | F_DONE);
    cyc("sat_ack", U | C_ACK | C_SAT, 4'd0, 4'd0, 4'b0000);
    cyc("sat_hold", U | C_STEP | C_SAT, 4'd0, 4'd1, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sct_step_counter.md
# sct_step_counter

Parametrised, registered successor to the combinational step-count control decode. It holds a WIDTH-bit step counter with global enable, synchronous clear, parallel load, up/down direction and an armed run/done sequencer. The enable/clear/load priority and the all-ones/all-zeros terminal decode now live in one clocked block. It sits between the sequencer front end, which issues `step` pulses, and the downstream status/strobe logic, which consumes `cnt`, `tc`, `co` and `done`.

## Interface
- `WIDTH`, 8, counter width in bits (2..32)
- `MAX_VAL`, 2**WIDTH-1, up-count terminal value; the down-count terminal is always 0

- `clk`  in  1  single clock; everything is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global enable; when low, `step`, `ld` and `arm` are ignored (`clr` still acts)
- `clr`  in  1  synchronous clear to 0
- `ld`  in  1  parallel load strobe
- `ld_val`  in  WIDTH  load value
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `sat`  in  1  saturate mode select (see Configuration)
- `step`  in  1  count-one-step request
- `arm`  in  1  start a run in IDLE
- `ack`  in  1  acknowledge `done`
- `cnt`  out  WIDTH  current count
- `tc`  out  1  terminal-count flag for the current direction
- `co`  out  1  one-cycle carry/borrow pulse on wrap
- `busy`  out  1  FSM is in RUN
- `done`  out  1  FSM is in DONE; held until acknowledged

## Operation
- Reset: `cnt`=0, `co`=0, FSM=IDLE, `busy`=0, `done`=0. `tc` follows its decode (1 when `up`=0).
- `tc` is decoded from the `cnt` register and the live `up` input: `up`=1 → `cnt`==MAX_VAL; `up`=0 → `cnt`==0.
- Per-cycle priority, highest first: `rst` > `clr` > (`en` & `ld`) > (`en` & `step`). Only the highest active item acts.
- Step, not at terminal: `cnt` ± 1.
- Step at terminal with wrap: `cnt` wraps to 0 (up) or MAX_VAL (down). `co`=1 for the next cycle only.
- MAX_VAL < 2**WIDTH-1: up-wrap goes from MAX_VAL to 0. Loaded values above MAX_VAL count up to 2**WIDTH-1, then wrap to 0 without asserting `tc`. `co` still pulses on that wrap.
- `ld_val` is taken verbatim, with no clamp.
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on `en` & `arm`.
  - RUN → DONE on a step accepted while `tc`=1. `cnt` still wraps/saturates that cycle.
  - DONE → IDLE on `ack`.
  - `clr` or `ld` in RUN → IDLE. `busy` drops on the next edge.
  - `arm` outside IDLE is ignored. `ack` outside DONE is ignored.
- Steps count in every state. The FSM only observes them.
- `en` low in RUN freezes both the FSM and `cnt`. There is no timeout.

## Timing
- Each accepted `step`/`ld`/`clr` updates `cnt` at the next rising edge (1-cycle latency).
- `tc` has zero added latency relative to `cnt` (combinational from the register and `up`).
- `co`, `busy` and `done` are registered and valid the cycle after the causing edge.
- `step` held high steps once per cycle. There is no edge detection.
- `done` and `ack` asserted together: DONE→IDLE. A simultaneous `arm` is ignored that cycle.
- `rst` mid-run aborts immediately and returns everything to reset values. No pulse is emitted.

## Configuration
- `SCT_SAT_EN` defined: when `sat`=1, a step at terminal holds `cnt` (no wrap) and `co` stays 0. The FSM still enters DONE from RUN. When `sat`=0, the counter wraps as above.
- `SCT_SAT_EN` undefined: `sat` is ignored, only wrap behaviour exists, and the saturation mux is not synthesised.

## Structure
- Package `sct_pkg` holds:
  - the FSM state enum (`SCT_IDLE`, `SCT_RUN`, `SCT_DONE`, 2-bit encoding);
  - the direction constants `SCT_UP`=1 and `SCT_DN`=0.
- One sub-module, `sct_next_cnt`: purely combinational. It computes next count, wrap flag and terminal decode from `cnt`, `up`, `sat` and MAX_VAL. The top level keeps the registers, the priority mux and the FSM.

## Test plan
- WIDTH=4, reset, `up`=1, `en`=1, `step` held for 16 cycles → `cnt` 0..15 then 0. `tc`=1 while `cnt`=15. `co`=1 exactly once, the cycle `cnt`=0 reappears.
- `ld`=1 with `ld_val`=3, `up`=0, then 4 steps → `cnt` 3,2,1,0,15. `co` pulses once after the step taken at 0.
- `arm`, load 13, `up`=1, steps → `busy` set. `done`=1 the cycle after the step taken at 15. Hold `ack`=0 for 3 cycles → `done` stays 1. `ack`=1 → `done`=0 and IDLE.
- Same cycle `clr`=1, `ld`=1 (`ld_val`=9), `step`=1 → `cnt`=0. In RUN, `busy`=0 next cycle.
- With `SCT_SAT_EN` and `sat`=1, WIDTH=4 at 15 stepping up → `cnt` stays 15, `co`=0, `done` asserts if in RUN. Without the macro, the same stimulus wraps to 0.
- `en`=0 with `step`, `ld` and `arm` active → `cnt` and FSM unchanged. `rst` during RUN at `cnt`=7 → `cnt`=0, `busy`=0, `done`=0 next cycle.
